uint_muler: RTL and testbench

UINT_MULER -- requirements
Module: uint_muler

---
 rtl/uint_muler_pkg.sv | 14 +
 rtl/uint_muler.sv | 83 ++++++++
 tb/tb_uint_muler.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/uint_muler_pkg.sv
// Shared width and FSM encodings for the uint_muler / uint_diver arithmetic blocks.
`ifndef DATAWIDTH
`define DATAWIDTH 32
`endif

package uint_muler_pkg;
    localparam int DATAWIDTH = `DATAWIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } muler_state_t;
endpackage

// File: rtl/uint_muler.sv
// Iterative shift-add unsigned multiplier: fixed datawidth iterations, result
// held in DONE until muler_en drops; dropping muler_en while BUSY aborts.
module uint_muler
    import uint_muler_pkg::*;
#(
    parameter int datawidth = DATAWIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 muler_en,
    input  logic [datawidth-1:0] multiplicand,
    input  logic [datawidth-1:0] multiplier,
    output logic [datawidth-1:0] product_hi,
    output logic [datawidth-1:0] product_lo,
    output logic                 busy,
    output logic                 end_flag
);
    localparam int CNT_W = $clog2(datawidth) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(datawidth);

    muler_state_t state, next_state;

    logic [2*datawidth-1:0] a_sh;
    logic [2*datawidth-1:0] acc;
    logic [datawidth-1:0]   b_sh;
    logic [CNT_W-1:0]       cnt;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (muler_en) next_state = BUSY;
            BUSY: begin
                if (!muler_en)        next_state = IDLE;
                else if (cnt == LAST) next_state = DONE;
            end
            DONE: if (!muler_en) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath: the extra BUSY cycle with cnt==LAST transfers acc to the outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh       <= '0;
            b_sh       <= '0;
            acc        <= '0;
            cnt        <= '0;
            product_hi <= '0;
            product_lo <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (muler_en) begin
                        a_sh <= {{datawidth{1'b0}}, multiplicand};
                        b_sh <= multiplier;
                        acc  <= '0;
                        cnt  <= '0;
                    end
                end
                BUSY: begin
                    if (muler_en && cnt != LAST) begin
                        if (b_sh[0]) acc <= acc + a_sh;
                        a_sh <= a_sh << 1;
                        b_sh <= b_sh >> 1;
                        cnt  <= cnt + CNT_W'(1);
                    end else if (muler_en) begin
                        product_hi <= acc[2*datawidth-1:datawidth];
                        product_lo <= acc[datawidth-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = (state == BUSY);
    assign end_flag = (state == DONE);
endmodule

// File: tb/tb_uint_muler.sv
// Scoreboard bench for uint_muler: random and corner operands against a plain
// 64-bit multiply, plus abort, reset-mid-operation and operand-churn cases.
module tb_uint_muler;
    logic        clk = 1'b0;
    logic        rst;
    logic        muler_en;
    logic [31:0] multiplicand, multiplier;
    logic [31:0] product_hi, product_lo;
    logic        busy, end_flag;

    uint_muler #(.datawidth(32)) dut (
        .clk(clk), .rst(rst), .muler_en(muler_en),
        .multiplicand(multiplicand), .multiplier(multiplier),
        .product_hi(product_hi), .product_lo(product_lo),
        .busy(busy), .end_flag(end_flag)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] prod;
        int          due;
    } exp_t;
    exp_t sb[$];

    int total = 0;
    int bad   = 0;
    logic [63:0] last_prod = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Starts an op and waits for its completion; the monitor checks the result.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input bit churn);
        logic [63:0] p;
        int n;
        p = 64'(a) * 64'(b);
        @(negedge clk);
        multiplicand = a;
        multiplier   = b;
        muler_en     = 1'b1;
        sb.push_back('{prod: p, due: cyc + 1 + 33});
        n = 0;
        while (!end_flag && n < 40) begin
            @(negedge clk);
            if (churn) begin
                multiplicand = $urandom;
                multiplier   = $urandom;
            end
            n++;
        end
        if (!end_flag) check("end_flag_timeout", 64'(end_flag), 64'd1);
        repeat (2) begin
            @(negedge clk);
            if (churn) begin
                multiplicand = $urandom;
                multiplier   = $urandom;
            end
            check("done_hold", {product_hi, product_lo, 1'b0} >> 1 | 64'(0), p);
            check("done_flag_hold", 64'(end_flag), 64'd1);
        end
        muler_en = 1'b0;
        @(negedge clk);
        check("idle_end_flag", 64'(end_flag), 64'd0);
        check("idle_prod_hold", {product_hi, product_lo}, p);
        last_prod = p;
    endtask

    initial begin
        bit prev_end = 1'b0;
        rst = 1'b1;
        muler_en = 1'b0;
        multiplicand = '0;
        multiplier = '0;

        fork
            forever begin
                @(negedge clk);
                if (end_flag && !prev_end) begin
                    if (sb.size() == 0) begin
                        check("unexpected_end_flag", 64'd1, 64'd0);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        check("product", {product_hi, product_lo}, e.prod);
                        check("latency", 64'(cyc), 64'(e.due));
                        check("busy_in_done", 64'(busy), 64'd0);
                    end
                end
                prev_end = end_flag;
            end
        join_none

        repeat (2) @(negedge clk);
        check("rst_outputs", {product_hi, product_lo}, 64'd0);
        check("rst_flags", {62'd0, busy, end_flag}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        do_op(32'd12, 32'd9, 1'b0);
        do_op(32'hFFFF_FFFF, 32'd3, 1'b0);
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        do_op(32'd0, 32'h1234, 1'b0);
        do_op(32'h8000_0000, 32'h8000_0000, 1'b0);

        // Abort at iteration 10: previous products must survive.
        @(negedge clk);
        multiplicand = 32'd12;
        multiplier   = 32'd9;
        muler_en     = 1'b1;
        repeat (11) @(negedge clk);
        check("abort_busy_before", 64'(busy), 64'd1);
        muler_en = 1'b0;
        @(negedge clk);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_end_flag", 64'(end_flag), 64'd0);
        check("abort_prod", {product_hi, product_lo}, last_prod);
        begin
            bit seen = 1'b0;
            repeat (40) begin
                @(negedge clk);
                if (end_flag || busy) seen = 1'b1;
            end
            check("abort_stays_idle", 64'(seen), 64'd0);
        end

        // Reset during BUSY.
        muler_en = 1'b1;
        multiplicand = 32'hDEAD_BEEF;
        multiplier   = 32'h1234_5678;
        repeat (15) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_prod", {product_hi, product_lo}, 64'd0);
        check("midrst_flags", {62'd0, busy, end_flag}, 64'd0);
        rst = 1'b0;
        muler_en = 1'b0;
        @(negedge clk);
        check("midrst_idle", {62'd0, busy, end_flag}, 64'd0);
        do_op(32'd5, 32'd7, 1'b0);

        // Operand churn during BUSY/DONE, then back-to-back randoms.
        do_op(32'd1000, 32'd3000, 1'b1);
        for (int i = 0; i < 8; i++) do_op($urandom, $urandom, i[0]);

        repeat (5) @(negedge clk);
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
